// File: rtl/shift_seq_ctrl_if.sv
// Request/result handshake bundle for the multi-cycle barrel shifter.
// The master drives requests and accepts results; the slave is the shifter.
interface shift_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic [7:0]  step_onehot;

  modport master (
    output in_valid, in_op, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_data, busy, step_onehot
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_data, busy, step_onehot
  );
endinterface

// File: rtl/shift_seq_ctrl.sv
// Sequential shifter: applies SLL/SRL/SRA in steps of at most STEP_MAX bits
// per cycle, with a valid/ready request port and a valid/ready result port.
module shift_seq_ctrl #(
  parameter int XLEN     = 32,
  parameter int STEP_MAX = 7
) (
  input logic            clk,
  input logic            rst_n,
  shift_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state;
  logic [XLEN-1:0]   work;
  logic [4:0]        rem;
  logic [1:0]        op_q;
  logic              sign_q;
  logic [2:0]        step;
  logic [4:0]        rem_next;
  logic [XLEN-1:0]   work_next;

  function automatic logic [2:0] min_step(input logic [4:0] r);
    return (r > 5'(STEP_MAX)) ? 3'(STEP_MAX) : r[2:0];
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] s);
    return 8'd1 << s;
  endfunction

  // Opcode 11 is treated as SRL; SRA fills with the sign captured at accept.
  function automatic logic [XLEN-1:0] shift_once(input logic [XLEN-1:0] v,
                                                 input logic [1:0] op,
                                                 input logic sign,
                                                 input logic [2:0] s);
    logic [XLEN-1:0] fill;
    fill = ~({XLEN{1'b1}} >> s) & {XLEN{sign}};
    case (op)
      2'b00:   return v << s;
      2'b10:   return (v >> s) | fill;
      default: return v >> s;
    endcase
  endfunction

  always_comb begin
    step      = min_step(rem);
    rem_next  = rem - {2'b00, step};
    work_next = shift_once(work, op_q, sign_q, step);
  end

  // step_onehot is precomputed one edge ahead so it is registered yet
  // describes the step being applied during the current SHIFT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      work            <= '0;
      rem             <= '0;
      op_q            <= '0;
      sign_q          <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.out_valid   <= 1'b0;
      bus.out_data    <= '0;
      bus.busy        <= 1'b0;
      bus.step_onehot <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            op_q         <= bus.in_op;
            sign_q       <= bus.in_data[XLEN-1];
            work         <= bus.in_data;
            rem          <= bus.in_shamt;
            bus.in_ready <= 1'b0;
            bus.busy     <= 1'b1;
            if (bus.in_shamt == 5'd0) begin
              state         <= DONE;
              bus.out_valid <= 1'b1;
              bus.out_data  <= bus.in_data;
            end else begin
              state           <= SHIFT;
              bus.step_onehot <= onehot(min_step(bus.in_shamt));
            end
          end
        end
        SHIFT: begin
          work <= work_next;
          rem  <= rem_next;
          if (rem_next == 5'd0) begin
            state           <= DONE;
            bus.out_valid   <= 1'b1;
            bus.out_data    <= work_next;
            bus.step_onehot <= '0;
          end else begin
            bus.step_onehot <= onehot(min_step(rem_next));
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: directed vector table, hand-built
// backpressure and mid-shift reset sequences, then random traffic vs a model.
module tb_shift_seq_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl #(.XLEN(32), .STEP_MAX(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [15];

  // Reference is the ISA definition of each shift on the whole amount at once.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d, input int sh);
    case (op)
      2'b00:   return d << sh;
      2'b10:   return 32'($signed(d) >>> sh);
      default: return d >> sh;
    endcase
  endfunction

  function automatic int ref_cycles(input int sh);
    return (sh + 6) / 7;
  endfunction

  function automatic logic [7:0] ref_step_onehot(input int sh, input int i);
    int n;
    int s;
    n = ref_cycles(sh);
    s = (i < n - 1) ? 7 : sh - 7 * (n - 1);
    return 8'd1 << s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic drive_noise();
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_op    = 2'($urandom_range(0, 3));
    bus.in_data  = $urandom;
    bus.in_shamt = 5'($urandom_range(0, 31));
  endtask

  // One full transaction starting at a negedge with the DUT idle; hold is the
  // number of DONE cycles with out_ready low before the result is taken.
  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data,
                               input logic [4:0] shamt, input logic [31:0] exp_data,
                               input int hold);
    int n;
    n = ref_cycles(int'(shamt));
    checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_data   = data;
    bus.in_shamt  = shamt;
    bus.out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= n; k++) begin
      checkOutput("shift_busy", 32'(bus.busy), 32'd1);
      checkOutput("shift_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("shift_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("step_onehot", 32'(bus.step_onehot), 32'(ref_step_onehot(int'(shamt), k - 1)));
      drive_noise();
      bus.out_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      checkOutput("done_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("done_out_data", bus.out_data, exp_data);
      checkOutput("done_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("done_busy", 32'(bus.busy), 32'd1);
      checkOutput("done_step", 32'(bus.step_onehot), 32'd0);
      drive_noise();
      bus.out_ready = (h == hold);
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("post_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("post_busy", 32'(bus.busy), 32'd0);
    checkOutput("post_out_data", bus.out_data, exp_data);
    checkOutput("post_step", 32'(bus.step_onehot), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_data;
    logic [4:0]  r_shamt;
    int          r_hold;

    vecs[0]  = '{2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000};
    vecs[1]  = '{2'b10, 32'h8000_0000, 5'd8,  32'hFF80_0000};
    vecs[2]  = '{2'b01, 32'h8000_0000, 5'd8,  32'h0080_0000};
    vecs[3]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[4]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[5]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[6]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
    vecs[7]  = '{2'b11, 32'hF000_0000, 5'd4,  32'h0F00_0000};
    vecs[8]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
    vecs[9]  = '{2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000};
    vecs[10] = '{2'b00, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FF80};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF, 5'd14, 32'h0003_FFFF};
    vecs[12] = '{2'b10, 32'h8000_0000, 5'd28, 32'hFFFF_FFF8};
    vecs[13] = '{2'b00, 32'h1234_5678, 5'd22, 32'h9E00_0000};
    vecs[14] = '{2'b10, 32'h4000_0000, 5'd15, 32'h0000_8000};

    checks        = 0;
    errors        = 0;
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.out_ready = 1'b0;

    #2;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", bus.out_data, 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_step", 32'(bus.step_onehot), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("first_out_data", bus.out_data, 32'd0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].op, vecs[i].data, vecs[i].shamt, vecs[i].exp_data, 0);
    end

    // Result held for three cycles under backpressure, then taken; the next
    // request is accepted on the very next edge.
    applyStimulus(2'b00, 32'h0000_00FF, 5'd4, 32'h0000_0FF0, 3);
    applyStimulus(2'b01, 32'h0000_0FF0, 5'd4, 32'h0000_00FF, 0);

    // Reset asserted during the second SHIFT cycle of a 20-bit SRL.
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_data  = 32'hA5A5_A5A5;
    bus.in_shamt = 5'd20;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("abort_step1", 32'(bus.step_onehot), 32'h80);
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_step2", 32'(bus.step_onehot), 32'h80);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_out_data", bus.out_data, 32'd0);
    checkOutput("abort_step", 32'(bus.step_onehot), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("abort_no_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("abort_idle_ready", 32'(bus.in_ready), 32'd1);
    end
    applyStimulus(2'b01, 32'hA5A5_A5A5, 5'd20, 32'h0000_0A5A, 0);

    for (int i = 0; i < 10000; i++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_data  = $urandom;
      r_shamt = 5'($urandom_range(0, 31));
      r_hold  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 4)) : 0;
      applyStimulus(r_op, r_data, r_shamt, ref_shift(r_op, r_data, int'(r_shamt)), r_hold);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
